// File: rtl/md_ctrl_pkg.sv
// rtl/md_ctrl_pkg.sv - op codes, state encoding and helpers shared by md_ctrl and its divider
package md_ctrl_pkg;

    localparam int MD_OP_WD = 2;

    localparam logic [MD_OP_WD-1:0] MD_MULT  = 2'b00;
    localparam logic [MD_OP_WD-1:0] MD_MULTU = 2'b01;
    localparam logic [MD_OP_WD-1:0] MD_DIV   = 2'b10;
    localparam logic [MD_OP_WD-1:0] MD_DIVU  = 2'b11;

    typedef enum logic [1:0] {
        MD_IDLE   = 2'b00,
        MD_MUL    = 2'b01,
        MD_DIVIDE = 2'b10,
        MD_DONE   = 2'b11
    } md_state_e;

    // Conditional two's-complement negate: magnitude on the way in, sign on the way out.
    function automatic logic [31:0] md_mag(input logic [31:0] v, input logic neg);
        return neg ? (32'd0 - v) : v;
    endfunction

endpackage

// File: rtl/md_ctrl_div_core.sv
// rtl/md_ctrl_div_core.sv - iterative restoring divider on 32-bit magnitudes, one bit per cycle
module md_ctrl_div_core #(
    parameter int DIV_ITER = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        kill,
    input  logic        start,
    input  logic [31:0] dividend,
    input  logic [31:0] divisor,
    output logic        ready,
    output logic [31:0] quot,
    output logic [31:0] rem
);
    localparam int CNT_W = $clog2(DIV_ITER + 1);

    logic [CNT_W-1:0] cnt;
    logic [31:0]      q_r;
    logic [31:0]      r_r;
    logic [31:0]      d_r;
    logic [32:0]      shifted;
    logic [32:0]      trial;
    logic             take;
    logic [31:0]      q_nxt;
    logic [31:0]      r_nxt;

    // The partial remainder stays below the divisor, so 32 bits hold it once the trial resolves.
    assign shifted = {r_r, q_r[31]};
    assign trial   = shifted - {1'b0, d_r};
    assign take    = ~trial[32];
    assign r_nxt   = take ? trial[31:0] : shifted[31:0];
    assign q_nxt   = {q_r[30:0], take};

    // Results are the post-iteration values so the last step lands in the same cycle as ready.
    assign ready = (cnt == CNT_W'(1));
    assign quot  = q_nxt;
    assign rem   = r_nxt;

    always_ff @(posedge clk) begin
        if (rst || kill) begin
            cnt <= '0;
            q_r <= '0;
            r_r <= '0;
            d_r <= '0;
        end else if (start) begin
            cnt <= CNT_W'(DIV_ITER);
            q_r <= dividend;
            r_r <= '0;
            d_r <= divisor;
        end else if (cnt != '0) begin
            cnt <= cnt - CNT_W'(1);
            q_r <= q_nxt;
            r_r <= r_nxt;
        end
    end

endmodule

// File: rtl/md_ctrl.sv
// rtl/md_ctrl.sv - multiply/divide sequencer holding EX and presenting HI/LO for one cycle
// Optional MD_EARLY_OUT_EN: divides with |a| < |b| finish without iterating.
module md_ctrl
    import md_ctrl_pkg::*;
#(
    parameter int MUL_LAT  = 1,
    parameter int DIV_ITER = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                start,
    input  logic [MD_OP_WD-1:0] op,
    input  logic [31:0]         src_a,
    input  logic [31:0]         src_b,
    output logic                stall_req,
    output logic                busy,
    output logic                done,
    output logic [31:0]         hi_wdata,
    output logic [31:0]         lo_wdata
);
    localparam int CNT_W = 6;

    md_state_e        state;
    md_state_e        state_nxt;
    logic [CNT_W-1:0] counter;
    logic [63:0]      prod;
    logic             q_neg;
    logic             r_neg;

    logic             is_div;
    logic             is_signed;
    logic             a_neg;
    logic             b_neg;
    logic             b_zero;
    logic             early;
    logic             issue;
    logic             div_start;
    logic             div_ready;
    logic [31:0]      mag_a;
    logic [31:0]      mag_b;
    logic [31:0]      div_quot;
    logic [31:0]      div_rem;
    logic [63:0]      ext_a;
    logic [63:0]      ext_b;

    assign is_div    = (op == MD_DIV) || (op == MD_DIVU);
    assign is_signed = (op == MD_MULT) || (op == MD_DIV);
    assign a_neg     = is_signed & src_a[31];
    assign b_neg     = is_signed & src_b[31];
    assign b_zero    = (src_b == 32'd0);
    assign mag_a     = md_mag(src_a, a_neg);
    assign mag_b     = md_mag(src_b, b_neg);
    assign ext_a     = {{32{a_neg}}, src_a};
    assign ext_b     = {{32{b_neg}}, src_b};
    assign issue     = (state == MD_IDLE) & start & ~flush;

`ifdef MD_EARLY_OUT_EN
    assign early = (mag_a < mag_b);
`else
    assign early = 1'b0;
`endif

    assign div_start = issue & is_div & ~b_zero & ~early;

    md_ctrl_div_core #(
        .DIV_ITER (DIV_ITER)
    ) u_div_core (
        .clk      (clk),
        .rst      (rst),
        .kill     (flush),
        .start    (div_start),
        .dividend (mag_a),
        .divisor  (mag_b),
        .ready    (div_ready),
        .quot     (div_quot),
        .rem      (div_rem)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= MD_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        stall_req = 1'b0;
        busy      = (state != MD_IDLE);
        done      = (state == MD_DONE);
        case (state)
            MD_IDLE: begin
                stall_req = start;
                if (start) begin
                    if (!is_div) begin
                        state_nxt = MD_MUL;
                    end else if (b_zero || early) begin
                        state_nxt = MD_DONE;
                    end else begin
                        state_nxt = MD_DIVIDE;
                    end
                end
            end
            MD_MUL: begin
                stall_req = 1'b1;
                if (counter == CNT_W'(1)) begin
                    state_nxt = MD_DONE;
                end
            end
            MD_DIVIDE: begin
                stall_req = 1'b1;
                if (div_ready) begin
                    state_nxt = MD_DONE;
                end
            end
            default: state_nxt = MD_IDLE;
        endcase
        if (flush) begin
            state_nxt = MD_IDLE;
            stall_req = 1'b0;
        end
    end

    // HI/LO only move on the edge entering DONE; a flush leaves them untouched.
    always_ff @(posedge clk) begin
        if (rst) begin
            counter  <= '0;
            prod     <= '0;
            q_neg    <= 1'b0;
            r_neg    <= 1'b0;
            hi_wdata <= '0;
            lo_wdata <= '0;
        end else if (!flush) begin
            case (state)
                MD_IDLE: begin
                    if (start) begin
                        prod    <= ext_a * ext_b;
                        q_neg   <= a_neg ^ b_neg;
                        r_neg   <= a_neg;
                        counter <= is_div ? CNT_W'(DIV_ITER) : CNT_W'(MUL_LAT);
                        if (is_div && (b_zero || early)) begin
                            hi_wdata <= src_a;
                            lo_wdata <= b_zero ? 32'hFFFF_FFFF : 32'd0;
                        end
                    end
                end
                MD_MUL: begin
                    counter <= counter - CNT_W'(1);
                    if (counter == CNT_W'(1)) begin
                        hi_wdata <= prod[63:32];
                        lo_wdata <= prod[31:0];
                    end
                end
                MD_DIVIDE: begin
                    counter <= counter - CNT_W'(1);
                    if (div_ready) begin
                        lo_wdata <= md_mag(div_quot, q_neg);
                        hi_wdata <= md_mag(div_rem, r_neg);
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
